// File: rtl/seg_pkg.sv
// seg_pkg: shared glyph table, blank constant and display-content record for the segment controller
package seg_pkg;
  localparam int MAX_DIGITS = 8;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  typedef struct packed {
    logic [4*MAX_DIGITS-1:0] value;
    logic [MAX_DIGITS-1:0]   dp;
    logic [MAX_DIGITS-1:0]   blink;
    logic                    blank_lz;
  } disp_cfg_t;
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    return GLYPH[h];
  endfunction
endpackage

// File: rtl/seg_display_ctrl_if.sv
// seg_display_ctrl_if: valid/ready load port carrying display content
interface seg_display_ctrl_if #(parameter int NUM_DIGITS = 6);
  logic                    load_valid;
  logic                    load_ready;
  logic [4*NUM_DIGITS-1:0] load_value;
  logic [NUM_DIGITS-1:0]   load_dp;
  logic [NUM_DIGITS-1:0]   load_blink;
  logic                    load_blank_lz;
  modport master (output load_valid, load_value, load_dp, load_blink, load_blank_lz, input load_ready);
  modport slave (input load_valid, load_value, load_dp, load_blink, load_blank_lz, output load_ready);
endinterface

// File: rtl/seg_scan_timer.sv
// seg_scan_timer: scan prescaler and digit index with per-digit tick and frame-wrap strobe
module seg_scan_timer #(
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV   = 50_000,
  parameter int IW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [IW-1:0] digit_idx,
  output logic          scan_tick,
  output logic          frame_wrap
);
  localparam int CW = $clog2(SCAN_DIV);
  logic [CW-1:0] cnt;
  assign scan_tick  = cnt == CW'(SCAN_DIV - 1);
  assign frame_wrap = scan_tick && digit_idx == IW'(NUM_DIGITS - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      digit_idx <= '0;
    end else begin
      cnt <= scan_tick ? '0 : cnt + 1'b1;
      if (scan_tick) digit_idx <= frame_wrap ? '0 : digit_idx + 1'b1;
    end
  end
endmodule

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: N-digit hex 7-segment controller with LZ blanking, blink and static/scan output
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25_000_000,
  parameter int SCAN_DIV   = 50_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seg_display_ctrl_if.slave       ld,
  input  logic                    scan_mode,
  output logic [8*NUM_DIGITS-1:0] segments,
  output logic [7:0]              scan_seg,
  output logic [NUM_DIGITS-1:0]   scan_sel
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = $clog2(BLINK_DIV);
  disp_cfg_t pend, act;
  logic pending, pending_n, phase, accept, commit, frame_wrap, unused_tick;
  logic [BW-1:0] bcnt;
  logic [IW-1:0] idx;
  logic [NUM_DIGITS-1:0] blk;
  logic [7:0] dbyte [NUM_DIGITS];
  seg_scan_timer #(.NUM_DIGITS(NUM_DIGITS), .SCAN_DIV(SCAN_DIV), .IW(IW)) u_timer (
    .clk(clk), .rst_n(rst_n), .digit_idx(idx), .scan_tick(unused_tick), .frame_wrap(frame_wrap)
  );
  assign accept    = ld.load_valid && ld.load_ready;
  assign commit    = pending && (!scan_mode || frame_wrap);
  assign pending_n = commit ? 1'b0 : accept ? 1'b1 : pending;
  always_comb begin
    logic going;
    going = act.blank_lz;
    blk   = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      blk[i] = going && act.value[4*i +: 4] == 4'h0 && !act.dp[i];
      going  = blk[i];
    end
    for (int i = 0; i < NUM_DIGITS; i++)
      dbyte[i] = (phase && act.blink[i]) ? SEG_BLANK :
                 blk[i] ? {~act.dp[i], 7'h7F} : {~act.dp[i], hex_to_seg(act.value[4*i +: 4])};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending       <= 1'b0;
      ld.load_ready <= 1'b0;
      pend          <= '0;
      act           <= '0;
      phase         <= 1'b0;
      bcnt          <= '0;
      segments      <= '1;
      scan_seg      <= '1;
      scan_sel      <= '1;
    end else begin
      pending       <= pending_n;
      ld.load_ready <= !pending_n;
      if (accept) begin
        pend.value    <= (4*MAX_DIGITS)'(ld.load_value);
        pend.dp       <= MAX_DIGITS'(ld.load_dp);
        pend.blink    <= MAX_DIGITS'(ld.load_blink);
        pend.blank_lz <= ld.load_blank_lz;
      end
      if (commit) act <= pend;
      bcnt <= (bcnt == BW'(BLINK_DIV - 1)) ? '0 : bcnt + 1'b1;
      if (bcnt == BW'(BLINK_DIV - 1)) phase <= !phase;
      for (int i = 0; i < NUM_DIGITS; i++) segments[8*i +: 8] <= scan_mode ? SEG_BLANK : dbyte[i];
      scan_seg <= scan_mode ? dbyte[idx] : SEG_BLANK;
      scan_sel <= scan_mode ? ~(NUM_DIGITS'(1) << idx) : '1;
    end
  end
  if (NUM_DIGITS < MAX_DIGITS) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^{act.value[4*MAX_DIGITS-1:4*NUM_DIGITS], act.dp[MAX_DIGITS-1:NUM_DIGITS],
                          act.blink[MAX_DIGITS-1:NUM_DIGITS]};
  end
endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb_seg_display_ctrl: directed checks of handshake, blanking, blink, scan commit and reset
module tb_seg_display_ctrl;
  localparam int N = 6;
  logic clk = 1'b0, rst_n = 1'b0, scan_mode = 1'b0;
  logic [8*N-1:0] segments;
  logic [7:0] scan_seg;
  logic [N-1:0] scan_sel;
  int checks = 0, errors = 0;
  seg_display_ctrl_if #(.NUM_DIGITS(N)) ld ();
  seg_display_ctrl #(.NUM_DIGITS(N), .BLINK_DIV(3), .SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .ld(ld), .scan_mode(scan_mode),
    .segments(segments), .scan_seg(scan_seg), .scan_sel(scan_sel)
  );
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive(input logic [23:0] v, input logic [5:0] dp, input logic [5:0] bl, input logic blz);
    ld.load_value = v; ld.load_dp = dp; ld.load_blink = bl; ld.load_blank_lz = blz;
  endtask

  task automatic do_load(input logic [23:0] v, input logic [5:0] dp, input logic [5:0] bl, input logic blz);
    int n = 0;
    drive(v, dp, bl, blz);
    ld.load_valid = 1'b1;
    while (!ld.load_ready && n < 100) begin step(1); n++; end
    checks++;
    if (ld.load_ready !== 1'b1) begin errors++; $display("FAIL ready_timeout got %b want 1", ld.load_ready); end
    step(1);
    ld.load_valid = 1'b0;
    checks++;
    if (ld.load_ready !== 1'b0) begin errors++; $display("FAIL ready_drop got %b want 0", ld.load_ready); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step(2);
    checks += 4;
    if (segments !== '1) begin errors++; $display("FAIL rst_segments got %h want all ones", segments); end
    if (scan_seg !== 8'hFF) begin errors++; $display("FAIL rst_scan_seg got %h want ff", scan_seg); end
    if (scan_sel !== '1) begin errors++; $display("FAIL rst_scan_sel got %b want 111111", scan_sel); end
    if (ld.load_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", ld.load_ready); end
    rst_n = 1'b1;
    step(1);
    checks += 2;
    if (ld.load_ready !== 1'b1) begin errors++; $display("FAIL rel_ready got %b want 1", ld.load_ready); end
    if (segments !== {N{8'hC0}}) begin errors++; $display("FAIL rel_segments got %h want c0..c0", segments); end
  endtask

  task automatic test_static;
    logic [23:0] vals [4] = '{24'h00012A, 24'h000000, 24'h0F00B3, 24'h000100};
    logic [5:0]  dps  [4] = '{6'b000000, 6'b001000, 6'b100001, 6'b000000};
    logic        blzs [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [47:0] exps [4] = '{48'hFFFFFFF9A488, 48'hFFFF40C0C0C0, 48'h408EC0C08330, 48'hFFFFFFF9C0C0};
    logic [47:0] prev = {N{8'hC0}};
    for (int i = 0; i < 4; i++) begin
      do_load(vals[i], dps[i], 6'b0, blzs[i]);
      step(1);
      checks++;
      if (segments !== prev) begin errors++; $display("FAIL static_t1_%0d got %h want %h", i, segments, prev); end
      step(1);
      checks += 4;
      if (segments !== exps[i]) begin errors++; $display("FAIL static_t2_%0d got %h want %h", i, segments, exps[i]); end
      if (ld.load_ready !== 1'b1) begin errors++; $display("FAIL static_ready_%0d got %b want 1", i, ld.load_ready); end
      if (scan_seg !== 8'hFF) begin errors++; $display("FAIL static_scan_seg_%0d got %h want ff", i, scan_seg); end
      if (scan_sel !== '1) begin errors++; $display("FAIL static_scan_sel_%0d got %b want 111111", i, scan_sel); end
      prev = exps[i];
    end
  endtask

  task automatic test_blink;
    logic [7:0] s [14];
    int k = 0;
    do_load(24'h000005, 6'b0, 6'b000001, 1'b0);
    step(2);
    for (int j = 0; j < 14; j++) begin
      s[j] = segments[7:0];
      checks += 2;
      if (s[j] !== 8'h92 && s[j] !== 8'hFF) begin errors++; $display("FAIL blink_d0_%0d got %h want 92 or ff", j, s[j]); end
      if (segments[47:8] !== {5{8'hC0}}) begin errors++; $display("FAIL blink_steady_%0d got %h want c0..c0", j, segments[47:8]); end
      step(1);
    end
    for (int j = 13; j >= 1; j--) if (s[j] !== s[j-1]) k = j;
    checks++;
    if (k < 1 || k > 3) begin errors++; $display("FAIL blink_first_toggle got %0d want 1..3", k); end
    else for (int j = k + 1; j < 14; j++) begin
      checks++;
      if ((s[j] !== s[j-1]) !== ((j - k) % 3 == 0)) begin
        errors++; $display("FAIL blink_period_%0d got %h->%h want toggle=%0d", j, s[j-1], s[j], (j - k) % 3 == 0);
      end
    end
    do_load(24'h123456, 6'b0, 6'b0, 1'b0);
    step(2);
  endtask

  task automatic test_scan;
    logic [7:0] ob [6] = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    logic [7:0] nb [6] = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82};
    logic [N-1:0] oh;
    int n = 0, idx;
    logic wrapped = 1'b0;
    scan_mode = 1'b1;
    step(1);
    checks++;
    if (segments !== '1) begin errors++; $display("FAIL scan_segments got %h want all ones", segments); end
    while (scan_sel !== 6'b111011 && n < 40) begin step(1); n++; end
    checks++;
    if (scan_sel !== 6'b111011) begin errors++; $display("FAIL scan_find_idx2 got %b want 111011", scan_sel); end
    drive(24'h654321, 6'b0, 6'b0, 1'b0);
    ld.load_valid = 1'b1;
    step(1);
    ld.load_valid = 1'b0;
    checks++;
    if (ld.load_ready !== 1'b0) begin errors++; $display("FAIL scan_accept got %b want 0", ld.load_ready); end
    for (int c = 0; c < 40 && !wrapped; c++) begin
      idx = -1;
      for (int k = 0; k < N; k++) begin oh = ~(N'(1) << k); if (scan_sel === oh) idx = k; end
      checks++;
      if (idx < 0) begin errors++; $display("FAIL scan_sel_onehot got %b want one low bit", scan_sel); end
      else if (idx == 0) begin
        wrapped = 1'b1;
        checks++;
        if (scan_seg !== nb[0]) begin errors++; $display("FAIL scan_new_d0 got %h want %h", scan_seg, nb[0]); end
        if (ld.load_ready !== 1'b1) begin errors++; $display("FAIL scan_ready_after_wrap got %b want 1", ld.load_ready); end
      end else begin
        if (scan_seg !== ob[idx]) begin errors++; $display("FAIL scan_old_d%0d got %h want %h", idx, scan_seg, ob[idx]); end
        if ((idx == 3 || idx == 4) && ld.load_ready !== 1'b0) begin
          errors++; $display("FAIL scan_ready_hold_d%0d got %b want 0", idx, ld.load_ready);
        end
      end
      if (!wrapped) step(1);
    end
    checks++;
    if (!wrapped) begin errors++; $display("FAIL scan_wrap_timeout got 0 want 1"); end
  endtask

  task automatic test_hold;
    int xfers = 0;
    drive(24'hABCDEF, 6'b0, 6'b0, 1'b0);
    ld.load_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (ld.load_valid && ld.load_ready) xfers++;
      step(1);
    end
    ld.load_valid = 1'b0;
    checks += 2;
    if (xfers !== 1) begin errors++; $display("FAIL hold_xfers got %0d want 1", xfers); end
    if (ld.load_ready !== 1'b0) begin errors++; $display("FAIL hold_pending got %b want 0", ld.load_ready); end
  endtask

  task automatic test_reset_mid;
    logic [N-1:0] oh;
    rst_n = 1'b0;
    step(1);
    checks += 4;
    if (segments !== '1) begin errors++; $display("FAIL mrst_segments got %h want all ones", segments); end
    if (scan_seg !== 8'hFF) begin errors++; $display("FAIL mrst_scan_seg got %h want ff", scan_seg); end
    if (scan_sel !== '1) begin errors++; $display("FAIL mrst_scan_sel got %b want 111111", scan_sel); end
    if (ld.load_ready !== 1'b0) begin errors++; $display("FAIL mrst_ready got %b want 0", ld.load_ready); end
    rst_n = 1'b1;
    step(1);
    checks++;
    if (ld.load_ready !== 1'b1) begin errors++; $display("FAIL mrel_ready got %b want 1", ld.load_ready); end
    for (int j = 0; j < 24; j++) begin
      oh = ~(N'(1) << (j / 4));
      checks += 2;
      if (scan_seg !== 8'hC0) begin errors++; $display("FAIL mrel_scan_seg_%0d got %h want c0", j, scan_seg); end
      if (scan_sel !== oh) begin errors++; $display("FAIL mrel_scan_sel_%0d got %b want %b", j, scan_sel, oh); end
      step(1);
    end
    scan_mode = 1'b0;
    step(1);
    checks += 3;
    if (segments !== {N{8'hC0}}) begin errors++; $display("FAIL mode_static_segments got %h want c0..c0", segments); end
    if (scan_sel !== '1) begin errors++; $display("FAIL mode_static_scan_sel got %b want 111111", scan_sel); end
    if (scan_seg !== 8'hFF) begin errors++; $display("FAIL mode_static_scan_seg got %h want ff", scan_seg); end
  endtask

  initial begin
    ld.load_valid = 1'b0;
    drive(24'h0, 6'b0, 6'b0, 1'b0);
    test_reset;
    test_static;
    test_blink;
    test_scan;
    test_hold;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
